// File: rtl/hive_ram_ctrl_pkg.sv
// Shared constants and state encoding for the hive sprite RAM controller.
// Also holds the in-bounds test used by both erase and collision logic.
`timescale 1ns/1ps
package hive_ram_ctrl_pkg;

  localparam int HIVE_W = 56;
  localparam int HIVE_H = 39;
  localparam int ADDR_W = 12;
  localparam logic [7:0] CLEAR_COLOUR = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic in_hive(input logic [6:0] px, input logic [6:0] py);
    return (px < 7'(HIVE_W)) && (py < 7'(HIVE_H));
  endfunction

endpackage

// File: rtl/hive_addr_calc.sv
// Pixel coordinate to hive RAM address, plus in-bounds flag.
// Purely combinational so it adds no latency wherever it is reused.
`timescale 1ns/1ps
module hive_addr_calc
  import hive_ram_ctrl_pkg::*;
(
  input  logic [6:0]        px,
  input  logic [6:0]        py,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  // py*56 as shift-add (32+16+8), truncated to the RAM address width
  assign addr = (ADDR_W'(py) << 5) + (ADDR_W'(py) << 4) + (ADDR_W'(py) << 3) + ADDR_W'(px);
  assign in_bounds = in_hive(px, py);

endmodule

// File: rtl/hive_ram_ctrl.sv
// Address/write owner of one hive sprite RAM: display reads during active
// video, crater-erase writes sequenced into blanking cycles.
`timescale 1ns/1ps
module hive_ram_ctrl
  import hive_ram_ctrl_pkg::*;
#(
  parameter int CRATER = 4
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic              blank,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              hit_req,
  input  logic [5:0]        hit_x,
  input  logic [5:0]        hit_y,
  output logic              hit_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [7:0]        ram_data
);

  localparam logic [2:0] LAST = 3'(CRATER - 1);

  state_t            state_reg, state_next;
  logic [5:0]        bx_reg, by_reg;
  logic [2:0]        cx_reg, cy_reg;
  logic              ack_reg;
  logic [6:0]        px, py;
  logic [ADDR_W-1:0] erase_addr;
  logic              in_bounds;
  logic              last_pixel;
  logic              erase_active;

  assign px = {1'b0, bx_reg} + {4'b0, cx_reg};
  assign py = {1'b0, by_reg} + {4'b0, cy_reg};
  assign last_pixel = (cx_reg == LAST) && (cy_reg == LAST);

  hive_addr_calc u_addr_calc (
    .px        (px),
    .py        (py),
    .addr      (erase_addr),
    .in_bounds (in_bounds)
  );

  always_ff @(posedge clk_pix) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (hit_req) state_next = ERASE;
      ERASE:   if (blank && last_pixel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters only move on blank cycles, so a paused pixel is retried, never skipped
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      bx_reg  <= '0;
      by_reg  <= '0;
      cx_reg  <= '0;
      cy_reg  <= '0;
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      if (state_reg == IDLE && hit_req) begin
        bx_reg  <= hit_x;
        by_reg  <= hit_y;
        cx_reg  <= '0;
        cy_reg  <= '0;
        ack_reg <= 1'b1;
      end else if (state_reg == ERASE && blank) begin
        if (cx_reg == LAST) begin
          cx_reg <= '0;
          cy_reg <= cy_reg + 3'd1;
        end else begin
          cx_reg <= cx_reg + 3'd1;
        end
      end
    end
  end

  always_comb begin
    erase_active = (state_reg == ERASE) && blank;
    ram_addr     = erase_active ? erase_addr : disp_addr;
    ram_write    = erase_active && in_bounds;
    ram_data     = CLEAR_COLOUR;
    busy         = (state_reg == ERASE);
    done         = (state_reg == DONE);
    hit_ack      = ack_reg;
  end

endmodule

// File: tb/tb_hive_ram_ctrl.sv
// Directed bench for hive_ram_ctrl: reset, full/paused/clipped craters,
// busy-time requests and reset in the middle of an erase.
`timescale 1ns/1ps
module tb_hive_ram_ctrl;

  logic        clk_pix = 1'b0;
  logic        reset, blank, hit_req;
  logic [11:0] disp_addr;
  logic [5:0]  hit_x, hit_y;
  logic        hit_ack, busy, done, ram_write;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int pause_bad = 0;
  int last_wr_cyc = 0;
  logic [11:0] wq_addr[$];
  logic [7:0]  wq_data[$];

  hive_ram_ctrl dut (
    .clk_pix   (clk_pix),
    .reset     (reset),
    .blank     (blank),
    .disp_addr (disp_addr),
    .hit_req   (hit_req),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .hit_ack   (hit_ack),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_data  (ram_data)
  );

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  // Observe the RAM side mid-cycle, away from the active edge
  always @(negedge clk_pix) begin
    if (cyc > 0) begin
      if (ram_write === 1'b1) begin
        wq_addr.push_back(ram_addr);
        wq_data.push_back(ram_data);
        last_wr_cyc = cyc;
      end
      if (blank === 1'b0 && (ram_write !== 1'b0 || ram_addr !== disp_addr)) pause_bad++;
      if (hit_ack === 1'b1) ack_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Request from IDLE; ack must appear in the very next cycle
  task automatic start_hit(input string tag, input int x, input int y, output int acyc);
    @(posedge clk_pix); #1;
    hit_x   = 6'(x);
    hit_y   = 6'(y);
    hit_req = 1'b1;
    @(posedge clk_pix); #2;
    chk({tag, "_ack"}, 32'(hit_ack), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    acyc    = cyc;
    hit_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk_pix); #2;
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_full(input string tag, input int x, input int y);
    chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'd16);
    if (wq_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk({tag, "_addr"}, 32'(wq_addr[i]), 32'((y + i / 4) * 56 + x + i % 4));
        chk({tag, "_data"}, 32'(wq_data[i]), 32'h00);
      end
    end
  endtask

  initial begin
    int acyc, dcyc, a0, d0, p0;
    int clip_exp[4];
    clip_exp = '{2126, 2127, 2182, 2183};

    reset = 1'b1; blank = 1'b0; hit_req = 1'b0;
    hit_x = '0; hit_y = '0; disp_addr = 12'h123;

    // 1: reset state
    repeat (3) @(posedge clk_pix);
    #2;
    chk("rst_addr", 32'(ram_addr), 32'h123);
    chk("rst_wr", 32'(ram_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(hit_ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // 2: full crater at (10,5)
    blank = 1'b1;
    clear_q();
    start_hit("t2", 10, 5, acyc);
    wait_done("t2", dcyc);
    chk("t2_done_lat", 32'(dcyc), 32'(last_wr_cyc + 1));
    chk("t2_busy_done", 32'(busy), 32'd0);
    check_full("t2", 10, 5);

    // 3: pause after 5 writes, resume later
    clear_q();
    p0 = pause_bad;
    start_hit("t3", 20, 10, acyc);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_pix); #1;
      if (wq_addr.size() >= 5) break;
    end
    blank = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_pix); #1;
      disp_addr = 12'h400 + 12'(i);
    end
    chk("t3_paused_nwr", 32'(wq_addr.size()), 32'd5);
    chk("t3_pause_bus", 32'(pause_bad), 32'(p0));
    disp_addr = 12'h123;
    blank = 1'b1;
    wait_done("t3", dcyc);
    check_full("t3", 20, 10);

    // 4: clipped crater at the bottom-right corner
    clear_q();
    start_hit("t4", 54, 37, acyc);
    wait_done("t4", dcyc);
    chk("t4_cycles", 32'(dcyc - acyc), 32'd16);
    chk("t4_nwr", 32'(wq_addr.size()), 32'd4);
    if (wq_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_addr", 32'(wq_addr[i]), 32'(clip_exp[i]));
    end

    // 5: request held while busy is serviced only after done
    clear_q();
    start_hit("t5", 30, 20, acyc);
    repeat (3) @(posedge clk_pix);
    #1;
    a0 = ack_cnt;
    hit_x = 6'd0; hit_y = 6'd0; hit_req = 1'b1;
    wait_done("t5a", dcyc);
    chk("t5_no_ack_busy", 32'(ack_cnt), 32'(a0));
    check_full("t5a", 30, 20);
    clear_q();
    acyc = -1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_pix); #2;
      if (hit_ack === 1'b1) begin
        acyc = cyc;
        break;
      end
    end
    chk("t5_ack_cycle", 32'(acyc), 32'(dcyc + 2));
    hit_req = 1'b0;
    wait_done("t5b", dcyc);
    check_full("t5b", 0, 0);

    // 6: reset after the 7th write
    clear_q();
    start_hit("t6", 10, 5, acyc);
    d0 = done_cnt;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_pix); #1;
      if (wq_addr.size() >= 7) break;
    end
    reset = 1'b1;
    @(posedge clk_pix); #2;
    chk("t6_wr_off", 32'(ram_write), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(ram_addr), 32'h123);
    reset = 1'b0;
    repeat (10) @(posedge clk_pix);
    #2;
    chk("t6_nwr", 32'(wq_addr.size()), 32'd7);
    if (wq_addr.size() == 7) chk("t6_last_addr", 32'(wq_addr[6]), 32'd348);
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
